// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversamples SCK/CS_N/MOSI in the clk domain, shifts FRAME_W-bit frames MSB first.
// Optional overrun/underrun flag enabled by defining SPI_SLV_OVERRUN_EN.
module spi_slave_if #(
    parameter int FRAME_W     = 41,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sck,
    input  logic               cs_n,
    input  logic               mosi,
    output logic               miso,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ack,
    output logic               busy,
    output logic               ovr,
    input  logic               ovr_clr,
    output logic [2:0]         state_dbg
);
    localparam int CNT_W = $clog2(FRAME_W + 1);

    // Handshake: tx_data is captured on any clk edge where tx_valid && tx_ready.
    // rx_valid is a level; rx_ack pulses clear it, a completed frame sets it (set wins).
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, HOLD} state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d, shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic shadow_full_q, shadow_full_d, rx_valid_q, rx_valid_d;
    logic miso_q, miso_d, busy_q, busy_d, ovr_q, ovr_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall, accept, ovr_set;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign accept   = tx_valid & ~shadow_full_q;

    always_comb begin
        state_d       = state_q;
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d    = sck_s;
        cs_prev_d     = cs_s;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        shift_tx_d    = shift_tx_q;
        shift_rx_d    = shift_rx_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        miso_d        = miso_q;
        bit_cnt_d     = bit_cnt_q;
        ovr_set       = 1'b0;

        if (accept) begin
            shadow_d      = tx_data;
            shadow_full_d = 1'b1;
        end
        if (rx_ack) rx_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                // An empty shadow sends an all-zero frame; a word accepted this cycle waits for the next frame.
                shift_tx_d    = shadow_full_q ? shadow_q : '0;
                shadow_full_d = accept;
                ovr_set       = ~shadow_full_q;
                miso_d        = shift_tx_d[FRAME_W-1];
                bit_cnt_d     = '0;
                state_d       = cs_s ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_s) begin
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    shift_rx_d = {shift_rx_q[FRAME_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_W'(FRAME_W)) begin
                        miso_d  = 1'b0;
                        state_d = DONE;
                    end
                end else if (sck_fall) begin
                    shift_tx_d = shift_tx_q << 1;
                    miso_d     = shift_tx_d[FRAME_W-1];
                end
            end
            DONE: begin
                rx_data_d  = shift_rx_q;
                rx_valid_d = 1'b1;
                ovr_set    = rx_valid_q;
                miso_d     = 1'b0;
                state_d    = cs_s ? IDLE : HOLD;
            end
            HOLD: begin
                miso_d = 1'b0;
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT) || (state_d == DONE) || (state_d == HOLD);
`ifdef SPI_SLV_OVERRUN_EN
        ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
`else
        ovr_d = 1'b0;
`endif
    end

`ifndef SPI_SLV_OVERRUN_EN
    logic unused_ovr;
    assign unused_ovr = ovr_clr | ovr_set | ovr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sck_sync_q    <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_prev_q    <= 1'b0;
            cs_prev_q     <= 1'b1;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            shift_tx_q    <= '0;
            shift_rx_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            miso_q        <= 1'b0;
            busy_q        <= 1'b0;
            ovr_q         <= 1'b0;
            bit_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sck_prev_q    <= sck_prev_d;
            cs_prev_q     <= cs_prev_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            shift_tx_q    <= shift_tx_d;
            shift_rx_q    <= shift_rx_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            miso_q        <= miso_d;
            busy_q        <= busy_d;
            ovr_q         <= ovr_d;
            bit_cnt_q     <= bit_cnt_d;
        end
    end

    assign miso      = miso_q;
    assign tx_ready  = ~shadow_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign ovr       = ovr_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: bit-banged SPI master plus a frame-level reference model.
module tb_spi_slave_if;
  localparam int FW = 41;
`ifdef SPI_SLV_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk, rst_n, sck, cs_n, mosi, miso;
  logic [FW-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_ack, busy, ovr, ovr_clr;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  // reference model: words preloaded but not yet sent, last full frame, flags
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] exp_rx;
  logic exp_rx_valid, exp_ovr;

  spi_slave_if #(.FRAME_W(FW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .ovr(ovr), .ovr_clr(ovr_clr), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    exp_rx = '0;
    exp_rx_valid = 1'b0;
    exp_ovr = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (rx_data !== exp_rx) begin
      n_fail++; $display("FAIL %s rx_data: got %h expected %h", tag, rx_data, exp_rx);
    end
    n_checks++;
    if (rx_valid !== exp_rx_valid) begin
      n_fail++; $display("FAIL %s rx_valid: got %b expected %b", tag, rx_valid, exp_rx_valid);
    end
    n_checks++;
    if (ovr !== exp_ovr) begin
      n_fail++; $display("FAIL %s ovr: got %b expected %b", tag, ovr, exp_ovr);
    end
    n_checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 || miso !== 1'b0) begin
      n_fail++; $display("FAIL %s idle: got busy=%b state=%0d miso=%b expected 0/0/0", tag, busy, state_dbg, miso);
    end
    n_checks++;
    if (tx_ready !== (exp_q.size() == 0)) begin
      n_fail++; $display("FAIL %s tx_ready: got %b expected %b", tag, tx_ready, exp_q.size() == 0);
    end
  endtask

  // driver tasks
  task automatic tx_load(input logic [FW-1:0] word);
    bit done = 0;
    @(negedge clk);
    tx_data = word;
    tx_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (tx_ready === 1'b1) done = 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL tx_load timeout: got tx_ready=%b expected 1 within 20 clk", tx_ready);
    end else begin
      exp_q.push_back(word);
      n_checks++;
      if (tx_ready !== 1'b0) begin
        n_fail++; $display("FAIL tx_load accept: got tx_ready=%b expected 0", tx_ready);
      end
    end
  endtask

  task automatic do_ack();
    @(negedge clk); rx_ack = 1'b1;
    @(negedge clk); rx_ack = 1'b0;
    exp_rx_valid = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL rx_ack: got rx_valid=%b expected 0", rx_valid);
    end
  endtask

  task automatic spi_xfer(input logic [FW-1:0] mosi_word, input int nbits, input string tag);
    logic [FW-1:0] exp_tx, got_tx, mask;
    int tail_ones;
    logic busy_mid;
    exp_tx = '0;
    if (exp_q.size() > 0) exp_tx = exp_q.pop_front();
    else if (OVR_EN) exp_ovr = 1'b1;
    got_tx = '0; tail_ones = 0; busy_mid = 1'b0;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < FW) ? mosi_word[FW-1-i] : 1'($urandom_range(0, 1));
      repeat (5) @(negedge clk);
      if (i < FW) got_tx[FW-1-i] = miso;
      else if (miso !== 1'b0) tail_ones++;
      if (i == 5) busy_mid = busy;
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    if (nbits >= FW) begin
      if (exp_rx_valid && OVR_EN) exp_ovr = 1'b1;
      exp_rx = mosi_word;
      exp_rx_valid = 1'b1;
    end
    mask = '1;
    if (nbits < FW) mask = ~(mask >> nbits);
    n_checks++;
    if ((got_tx & mask) !== (exp_tx & mask)) begin
      n_fail++; $display("FAIL %s miso_word: got %h expected %h", tag, got_tx & mask, exp_tx & mask);
    end
    n_checks++;
    if (tail_ones !== 0) begin
      n_fail++; $display("FAIL %s miso_tail: got %0d ones expected 0", tag, tail_ones);
    end
    n_checks++;
    if (busy_mid !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_mid: got %b expected 1", tag, busy_mid);
    end
    check_idle_outputs(tag);
  endtask

  // scenario tasks
  task automatic test_reset();
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0; ovr_clr = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
  endtask

  task automatic test_preload_frame();
    tx_load(41'h0_1234_5678_9A);
    spi_xfer(41'h1_5555_5555_55, FW, "preload");
    do_ack();
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 4; n++) begin
      tx_load({9'($urandom), $urandom});
      spi_xfer({9'($urandom), $urandom}, FW, "random");
      do_ack();
    end
  endtask

  task automatic test_no_preload();
    spi_xfer({9'($urandom), $urandom}, FW, "no_preload");
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    n_checks++;
    if (ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clr: got %b expected 0", ovr);
    end
    do_ack();
  endtask

  task automatic test_short_frame();
    tx_load({9'($urandom), $urandom});
    spi_xfer({9'($urandom), $urandom}, 20, "short");
  endtask

  task automatic test_back_to_back();
    spi_xfer(41'h0_AAAA_AAAA_AA, FW, "b2b_first");
    spi_xfer(41'h1_5555_5555_55, FW, "b2b_second");
    do_ack();
  endtask

  task automatic test_long_frame();
    tx_load({9'($urandom), $urandom});
    spi_xfer({9'($urandom), $urandom}, 45, "long");
  endtask

  task automatic test_reset_mid_frame();
    logic [FW-1:0] w;
    w = {9'($urandom), $urandom};
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mosi = w[FW-1-i];
      repeat (5) @(negedge clk); sck = 1'b1;
      repeat (5) @(negedge clk); sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (busy !== 1'b0 || state_dbg !== 3'd0 || rx_valid !== 1'b0 || rx_data !== '0 ||
        tx_ready !== 1'b1 || ovr !== 1'b0 || miso !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b state=%0d rx_valid=%b rx_data=%h tx_ready=%b ovr=%b miso=%b expected 0/0/0/0/1/0/0",
               busy, state_dbg, rx_valid, rx_data, tx_ready, ovr, miso);
    end
    cs_n = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_load({9'($urandom), $urandom});
    spi_xfer({9'($urandom), $urandom}, FW, "after_reset");
  endtask

  initial begin
    test_reset();
    test_preload_frame();
    test_random_frames();
    test_no_preload();
    test_short_frame();
    test_back_to_back();
    test_long_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
